icb_slave_ram: RTL and testbench
================================

Name: icb_slave_ram

Overview:
- ICB responder that fronts a word-addressed on-chip SRAM.
- Sits at the far end of the accelerator's ICB master port and serves its weight/imap reads and omap writes.
- Accepts one command per cycle and returns responses strictly in order through a 2-entry response FIFO.
- Fully honours back-pressure on the response channel.

Parameters:
- AW, 12: word-address bits; memory depth is 2^AW 32-bit words.
- BASE_ADDR, 32'h1000_0000: byte address of word 0; must be aligned to 4*2^AW.
- ZERO_MASK_FULL, 1: when 1, a write with wmask 4'b0000 writes all 4 bytes. When 0, such a write changes nothing.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high. One clock; reset is synchronous and active-high.
- icb_cmd_valid  in  1  command valid.
- icb_cmd_ready  out  1  command ready.
- icb_cmd_addr  in  32  byte address.
- icb_cmd_read  in  1  1 = read, 0 = write.
- icb_cmd_wdata  in  32  write data.
- icb_cmd_wmask  in  4  byte enables; bit i covers wdata[8i+7:8i].
- icb_rsp_valid  out  1  response valid.
- icb_rsp_ready  in  1  response ready.
- icb_rsp_err  out  1  response error flag.
- icb_rsp_rdata  out  32  read data.

Behaviour:
- **Reset.**
  - While rst is high: icb_cmd_ready=0, icb_rsp_valid=0, icb_rsp_err=0, icb_rsp_rdata=0.
  - FIFO write pointer, read pointer and occupancy count are cleared to 0.
  - SRAM contents are not reset.
  - Reset mid-operation discards all queued responses; no partial responses are delivered after reset.
- **Command accept.**
  - Accept happens at an edge where icb_cmd_valid & icb_cmd_ready is high.
  - icb_cmd_ready = !rst & (count < 2). It has no combinational path from icb_rsp_ready.
  - An unaccepted command may change freely; the block samples only at accept.
- **Address decode.**
  - idx = (addr - BASE_ADDR) >> 2.
  - err = addr[1:0] != 0, or addr < BASE_ADDR, or addr >= BASE_ADDR + 4*2^AW.
- **Read.**
  - At the accept edge, push {err, data} into the FIFO.
  - data = mem[idx] when err=0, else 0.
  - Read-after-write is coherent: a read accepted at the edge after a write returns the new data.
- **Write.**
  - At the accept edge, if err=0, write each byte i with wmask[i]=1 (with ZERO_MASK_FULL applied).
  - Push {err, 32'h0} into the FIFO.
  - An erroring write modifies no memory.
- **Response.**
  - icb_rsp_valid = (count != 0).
  - icb_rsp_err and icb_rsp_rdata come from the FIFO head and are forced to 0 when icb_rsp_valid=0.
  - A pop happens at an edge where icb_rsp_valid & icb_rsp_ready is high.
  - Head fields stay stable while valid & !ready.
- **Latency.** A command accepted at edge N gives icb_rsp_valid=1 in the cycle after N.
- **Throughput.** With icb_rsp_ready held high, one command is accepted and one response returned every cycle (occupancy stays at 1).
- **Occupancy count.**
  - push only: count+1. pop only: count-1. Push and pop together: count unchanged.
  - Pointers are 1 bit and wrap 1→0.
- **Full.**
  - count==2 gives cmd_ready=0, so no push can occur.
  - A pop at edge M raises cmd_ready in the cycle after M.
- **Empty.** A pop is impossible because rsp_valid=0. Push and pop in the same edge at count==1 are legal.
- **Ordering.** Responses leave in strict accept order; the ICB response carries no ID.

Test Plan:
1. Write addr 0x1000_0010, wdata 0xDEADBEEF, wmask 4'hF; read the same addr next cycle → two responses: err=0 rdata=0, then err=0 rdata=0xDEADBEEF, each valid one cycle after its accept.
2. Preload word 0x1000_0020 = 0x11223344; write wdata 0xAABBCCDD wmask 4'b0101; read → rdata=0x11BB33DD. Repeat with wmask 4'b0000 and ZERO_MASK_FULL=1 → rdata=0xAABBCCDD.
3. Back-pressure: hold rsp_ready=0 and issue 4 back-to-back reads → exactly 2 accepted, cmd_ready=0 from the third cycle, head rdata stable. Raise rsp_ready → remaining reads accepted; all 4 responses arrive in order with correct data.
4. Streaming: rsp_ready=1, 16 consecutive reads of ascending addresses → 16 accepts in 16 cycles, rsp_valid continuous, data in order.
5. Errors:
   - read 0x0FFF_FFFC → err=1 rdata=0.
   - write 0x1000_4000 (AW=12) → err=1, memory unchanged.
   - read 0x1000_0002 → err=1.
   - a following legal read → err=0.
6. Assert rst for 1 cycle with 2 responses queued → rsp_valid=0 and cmd_ready=0 during reset. After reset, cmd_ready=1, no stale responses appear, and memory written before reset still reads back.

Source files
------------

// File: rtl/icb_slave_ram_if.sv
// icb_slave_ram_if: ICB command/response bus between a master and the RAM responder
// master drives cmd_valid/addr/read/wdata/wmask and rsp_ready; slave drives cmd_ready and rsp_valid/err/rdata
interface icb_slave_ram_if;
  logic        icb_cmd_valid;
  logic        icb_cmd_ready;
  logic [31:0] icb_cmd_addr;
  logic        icb_cmd_read;
  logic [31:0] icb_cmd_wdata;
  logic [3:0]  icb_cmd_wmask;
  logic        icb_rsp_valid;
  logic        icb_rsp_ready;
  logic        icb_rsp_err;
  logic [31:0] icb_rsp_rdata;
  modport master (
    output icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_wmask, icb_rsp_ready,
    input  icb_cmd_ready, icb_rsp_valid, icb_rsp_err, icb_rsp_rdata
  );
  modport slave (
    input  icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_wmask, icb_rsp_ready,
    output icb_cmd_ready, icb_rsp_valid, icb_rsp_err, icb_rsp_rdata
  );
endinterface

// File: rtl/icb_slave_ram.sv
// icb_slave_ram: ICB responder over a 2^AW x 32-bit SRAM with an in-order 2-entry response FIFO
// ports: clk, rst (sync active-high), icb (icb_slave_ram_if.slave: cmd channel in, rsp channel out)
module icb_slave_ram #(
  parameter int          AW             = 12,
  parameter logic [31:0] BASE_ADDR      = 32'h1000_0000,
  parameter bit          ZERO_MASK_FULL = 1'b1
) (
  input logic           clk,
  input logic           rst,
  icb_slave_ram_if.slave icb
);
  logic [31:0]   r_mem [2**AW];
  logic [31:0]   r_data [2];
  logic          r_err [2];
  logic          r_wptr;
  logic          r_rptr;
  logic [1:0]    r_cnt;
  logic [31:0]   w_off;
  logic [AW-1:0] w_idx;
  logic          w_err;
  logic [3:0]    w_mask;
  logic [31:0]   w_rd;
  logic          w_push;
  logic          w_pop;
  // BASE_ADDR is aligned, so offset low bits equal address low bits and any
  // high offset bit means out of range (below-base wraps to a large offset too)
  assign w_off  = icb.icb_cmd_addr - BASE_ADDR;
  assign w_idx  = w_off[AW+1:2];
  assign w_err  = (|w_off[1:0]) | (|w_off[31:AW+2]) | (icb.icb_cmd_addr < BASE_ADDR);
  assign w_mask = (icb.icb_cmd_wmask == 4'h0 && ZERO_MASK_FULL) ? 4'hF : icb.icb_cmd_wmask;
  assign w_rd   = (w_err || !icb.icb_cmd_read) ? 32'h0 : r_mem[w_idx];
  assign icb.icb_cmd_ready = !rst && r_cnt < 2'd2;
  assign icb.icb_rsp_valid = !rst && r_cnt != 2'd0;
  assign icb.icb_rsp_err   = icb.icb_rsp_valid ? r_err[r_rptr] : 1'b0;
  assign icb.icb_rsp_rdata = icb.icb_rsp_valid ? r_data[r_rptr] : 32'h0;
  assign w_push = icb.icb_cmd_valid && icb.icb_cmd_ready;
  assign w_pop  = icb.icb_rsp_valid && icb.icb_rsp_ready;
  always_ff @(posedge clk) begin
    if (w_push && !icb.icb_cmd_read && !w_err)
      for (int i = 0; i < 4; i++)
        if (w_mask[i]) r_mem[w_idx][8*i +: 8] <= icb.icb_cmd_wdata[8*i +: 8];
  end
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_err[r_wptr]  <= w_err;
      r_data[r_wptr] <= w_rd;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
      r_cnt  <= 2'd0;
    end else begin
      if (w_push) r_wptr <= ~r_wptr;
      if (w_pop) r_rptr <= ~r_rptr;
      r_cnt <= r_cnt + 2'(w_push) - 2'(w_pop);
    end
  end
endmodule

// File: tb/tb_icb_slave_ram.sv
// tb_icb_slave_ram: randomized check of icb_slave_ram against a word-array/response-queue model
module tb_icb_slave_ram;
  localparam logic [31:0] BASE = 32'h1000_0000;
  typedef struct {
    logic        rd;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  m;
  } cmd_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  icb_slave_ram_if bus ();
  icb_slave_ram dut (.clk(clk), .rst(rst), .icb(bus));
  always #5 clk = ~clk;
  cmd_t        pend[$];
  logic [32:0] rspq[$];
  logic [31:0] mdl [4096];
  int n_chk = 0;
  int n_fail = 0;
  int n_acc = 0;
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic bit is_err(logic [31:0] a);
    return (a % 4) != 0 || a < BASE || a >= BASE + 32'd16384;
  endfunction
  task automatic push_cmd(bit rd, logic [31:0] a, logic [31:0] d, logic [3:0] m);
    cmd_t c;
    c.rd = rd; c.a = a; c.d = d; c.m = m;
    pend.push_back(c);
  endtask
  task automatic cycle(bit r, bit rdy, bit vld);
    bit ev, er, e;
    int w;
    cmd_t c;
    logic [31:0] word;
    logic [3:0] m;
    @(negedge clk);
    rst = r;
    bus.icb_rsp_ready = rdy;
    bus.icb_cmd_valid = vld && pend.size() > 0;
    if (pend.size() > 0) begin
      bus.icb_cmd_read  = pend[0].rd;
      bus.icb_cmd_addr  = pend[0].a;
      bus.icb_cmd_wdata = pend[0].d;
      bus.icb_cmd_wmask = pend[0].m;
    end
    #1;
    ev = !r && rspq.size() > 0;
    er = !r && rspq.size() < 2;
    chk("rsp_valid", 64'(bus.icb_rsp_valid), 64'(ev));
    chk("cmd_ready", 64'(bus.icb_cmd_ready), 64'(er));
    chk("rsp_err", 64'(bus.icb_rsp_err), ev ? 64'(rspq[0][32]) : 64'd0);
    chk("rsp_rdata", 64'(bus.icb_rsp_rdata), ev ? 64'(rspq[0][31:0]) : 64'd0);
    if (r) begin
      rspq.delete();
      return;
    end
    if (ev && rdy) void'(rspq.pop_front());
    if (bus.icb_cmd_valid && er) begin
      c = pend.pop_front();
      n_acc++;
      e = is_err(c.a);
      w = int'((c.a - BASE) / 4);
      if (c.rd) rspq.push_back({e, e ? 32'h0 : mdl[w]});
      else begin
        if (!e) begin
          word = mdl[w];
          m = (c.m == 4'h0) ? 4'hF : c.m;
          for (int i = 0; i < 4; i++)
            if (m[i]) word[8*i +: 8] = c.d[8*i +: 8];
          mdl[w] = word;
        end
        rspq.push_back({e, 32'h0});
      end
    end
  endtask
  task automatic run(int n, int mode);
    for (int k = 0; k < n; k++)
      cycle(1'b0, mode == 1 ? 1'b1 : mode == 0 ? 1'b0 : 1'($urandom_range(0, 1)),
            mode == 2 ? ($urandom_range(0, 3) != 0) : 1'b1);
  endtask
  task automatic drain(int mode);
    int k = 0;
    while ((pend.size() > 0 || rspq.size() > 0) && k < 2000) begin
      run(1, mode);
      k++;
    end
    chk("drain_done", 64'(pend.size() + rspq.size()), 64'd0);
  endtask
  initial begin
    bus.icb_cmd_valid = 1'b0;
    bus.icb_cmd_read  = 1'b0;
    bus.icb_cmd_addr  = 32'h0;
    bus.icb_cmd_wdata = 32'h0;
    bus.icb_cmd_wmask = 4'h0;
    bus.icb_rsp_ready = 1'b0;
    cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 64; i++) push_cmd(1'b0, BASE + 32'(4 * i), $urandom, 4'hF);
    drain(1);
    push_cmd(1'b0, 32'h1000_0010, 32'hDEAD_BEEF, 4'hF);
    push_cmd(1'b1, 32'h1000_0010, $urandom, 4'h0);
    drain(1);
    push_cmd(1'b0, 32'h1000_0020, 32'h1122_3344, 4'hF);
    push_cmd(1'b0, 32'h1000_0020, 32'hAABB_CCDD, 4'b0101);
    push_cmd(1'b1, 32'h1000_0020, 32'h0, 4'h0);
    push_cmd(1'b0, 32'h1000_0020, 32'hAABB_CCDD, 4'b0000);
    push_cmd(1'b1, 32'h1000_0020, 32'h0, 4'h0);
    drain(1);
    chk("mask_model", 64'(mdl[8]), 64'hAABB_CCDD);
    for (int i = 0; i < 4; i++) push_cmd(1'b1, BASE + 32'(4 * i), 32'h0, 4'h0);
    n_acc = 0;
    run(4, 0);
    chk("bp_accepts", 64'(n_acc), 64'd2);
    drain(1);
    chk("bp_total", 64'(n_acc), 64'd4);
    for (int i = 0; i < 16; i++) push_cmd(1'b1, BASE + 32'(4 * i), 32'h0, 4'h0);
    n_acc = 0;
    run(16, 1);
    chk("stream_accepts", 64'(n_acc), 64'd16);
    drain(1);
    push_cmd(1'b1, 32'h0FFF_FFFC, 32'h0, 4'h0);
    push_cmd(1'b0, 32'h1000_4000, 32'h5555_AAAA, 4'hF);
    push_cmd(1'b1, 32'h1000_0002, 32'h0, 4'h0);
    push_cmd(1'b1, 32'h1000_0000, 32'h0, 4'h0);
    drain(1);
    push_cmd(1'b0, 32'h1000_0030, 32'hCAFE_F00D, 4'hF);
    drain(1);
    push_cmd(1'b1, 32'h1000_0004, 32'h0, 4'h0);
    push_cmd(1'b1, 32'h1000_0008, 32'h0, 4'h0);
    run(3, 0);
    chk("pre_reset_q", 64'(rspq.size()), 64'd2);
    cycle(1'b1, 1'b0, 1'b0);
    push_cmd(1'b1, 32'h1000_0030, 32'h0, 4'h0);
    push_cmd(1'b1, 32'h1000_0010, 32'h0, 4'h0);
    drain(1);
    for (int i = 0; i < 400; i++) begin
      int sel = $urandom_range(0, 9);
      logic [31:0] a;
      a = sel == 0 ? 32'h0FFF_FFFC : sel == 1 ? 32'h1000_4000 + 32'(4 * $urandom_range(0, 3)) :
          sel == 2 ? BASE + 32'($urandom_range(0, 255)) : BASE + 32'(4 * $urandom_range(0, 63));
      push_cmd(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
    end
    drain(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
